// File: rtl/rs_issue_scheduler_pkg.sv
// Shared sizing parameters and uOP record types for the reservation-station issue scheduler.
// Disp_uOP is what dispatch writes into a slot; Sel_uOP is the subset handed to a functional unit.
package rs_issue_scheduler_pkg;

    localparam int RS_ENTRIES = 8;
    localparam int NUM_FUS    = 4;
    localparam int NUM_PREGS  = 64;
    localparam int NUM_WB     = 2;
    localparam int PREG_W     = $clog2(NUM_PREGS);
    localparam int FU_W       = $clog2(NUM_FUS);
    localparam int CNT_W      = $clog2(RS_ENTRIES + 1);
    localparam int PAYLOAD_W  = 16;

    typedef struct packed {
        logic [FU_W-1:0]      fu_id;
        logic [PREG_W-1:0]    src1;
        logic [PREG_W-1:0]    src2;
        logic                 src1_rdy;
        logic                 src2_rdy;
        logic [PREG_W-1:0]    dest;
        logic [PAYLOAD_W-1:0] payload;
    } Disp_uOP;

    typedef struct packed {
        logic [FU_W-1:0]      fu_id;
        logic [PREG_W-1:0]    src1;
        logic [PREG_W-1:0]    src2;
        logic [PREG_W-1:0]    dest;
        logic [PAYLOAD_W-1:0] payload;
    } Sel_uOP;

    function automatic Sel_uOP toSel(input Disp_uOP u);
        Sel_uOP s;
        s.fu_id   = u.fu_id;
        s.src1    = u.src1;
        s.src2    = u.src2;
        s.dest    = u.dest;
        s.payload = u.payload;
        return s;
    endfunction

endpackage

// File: rtl/rs_issue_scheduler_age.sv
// Age matrix: bit [i][j] set means slot i was allocated before slot j.
// Each FU's grant is the requesting slot that no other requesting slot is older than.
module rs_age_matrix
    import rs_issue_scheduler_pkg::*;
(
    input  logic                                clk,
    input  logic                                rst,
    input  logic [RS_ENTRIES-1:0]               alloc_i,
    input  logic [RS_ENTRIES-1:0]               free_i,
    input  logic [NUM_FUS-1:0][RS_ENTRIES-1:0]  req_i,
    output logic [NUM_FUS-1:0][RS_ENTRIES-1:0]  grant_o
);

    logic [RS_ENTRIES-1:0][RS_ENTRIES-1:0] older_q, older_d;

    // A newly allocated slot is older than nobody and younger than every other slot;
    // stale bits of invalid slots are harmless because invalid slots never request.
    always_comb begin
        older_d = older_q;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            if (free_i[i]) begin
                for (int j = 0; j < RS_ENTRIES; j++) begin
                    older_d[i][j] = 1'b0;
                    older_d[j][i] = 1'b0;
                end
            end
        end
        for (int i = 0; i < RS_ENTRIES; i++) begin
            if (alloc_i[i]) begin
                for (int j = 0; j < RS_ENTRIES; j++) begin
                    older_d[i][j] = 1'b0;
                    if (j != i) older_d[j][i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) older_q <= '0;
        else     older_q <= older_d;
    end

    always_comb begin
        grant_o = '0;
        for (int f = 0; f < NUM_FUS; f++) begin
            for (int e = 0; e < RS_ENTRIES; e++) begin
                grant_o[f][e] = req_i[f][e];
                for (int j = 0; j < RS_ENTRIES; j++) begin
                    if (req_i[f][j] && older_q[j][e]) grant_o[f][e] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/rs_issue_scheduler.sv
// Reservation station: holds dispatched uOPs, wakes sources on writeback tags,
// and issues the oldest ready uOP per functional unit over valid/ready.
module rs_issue_scheduler
    import rs_issue_scheduler_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        disp_valid,
    output logic                        disp_ready,
    input  Disp_uOP                     disp_uop,
    input  logic [NUM_WB-1:0]           wb_valid,
    input  logic [NUM_WB*PREG_W-1:0]    wb_preg,
    output logic [NUM_FUS-1:0]          iss_valid,
    input  logic [NUM_FUS-1:0]          iss_ready,
    output Sel_uOP [NUM_FUS-1:0]        iss_uop,
    output logic [CNT_W-1:0]            rs_count
);

    logic [RS_ENTRIES-1:0]              valid_q, valid_d;
    Disp_uOP                            entry_q [RS_ENTRIES];
    Disp_uOP                            entry_d [RS_ENTRIES];
    logic [CNT_W-1:0]                   count_q, count_d;

    logic [RS_ENTRIES-1:0]              allocOh, eligible, issueFree, ageAlloc, ageFree;
    logic [NUM_FUS-1:0][RS_ENTRIES-1:0] fuReq, fuGrant;
    logic [NUM_FUS-1:0]                 issFire;
    logic [CNT_W-1:0]                   issCount;
    logic                               dispFire;

    function automatic logic wbHit(input logic [PREG_W-1:0] tag,
                                   input logic [NUM_WB-1:0] wbv,
                                   input logic [NUM_WB*PREG_W-1:0] wbp);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_WB; k++) begin
            if (wbv[k] && (wbp[k*PREG_W +: PREG_W] == tag)) hit = 1'b1;
        end
        return hit;
    endfunction

    always_comb begin
        allocOh = '0;
        for (int e = 0; e < RS_ENTRIES; e++) begin
            if (!valid_q[e] && (allocOh == '0)) allocOh[e] = 1'b1;
        end
    end

    // Dispatch looks only at current occupancy, so a slot freed by this cycle's issue waits a cycle.
    assign disp_ready = !rst && !flush && !(&valid_q);
    assign dispFire   = disp_valid && disp_ready;

    always_comb begin
        eligible = '0;
        fuReq    = '0;
        for (int e = 0; e < RS_ENTRIES; e++) begin
            eligible[e] = valid_q[e] && entry_q[e].src1_rdy && entry_q[e].src2_rdy;
            for (int f = 0; f < NUM_FUS; f++) begin
                fuReq[f][e] = eligible[e] && (entry_q[e].fu_id == FU_W'(f));
            end
        end
    end

    rs_age_matrix u_age (
        .clk     (clk),
        .rst     (rst),
        .alloc_i (ageAlloc),
        .free_i  (ageFree),
        .req_i   (fuReq),
        .grant_o (fuGrant)
    );

    always_comb begin
        iss_uop   = '0;
        issueFree = '0;
        issCount  = '0;
        for (int f = 0; f < NUM_FUS; f++) begin
            iss_valid[f] = |fuReq[f];
            issFire[f]   = iss_valid[f] && iss_ready[f];
            for (int e = 0; e < RS_ENTRIES; e++) begin
                if (fuGrant[f][e]) iss_uop[f] = toSel(entry_q[e]);
            end
            if (issFire[f]) issueFree = issueFree | fuGrant[f];
            issCount = issCount + CNT_W'(issFire[f]);
        end
    end

    // Flush overrides everything but reset; otherwise wakeup, issue-free and dispatch-write combine.
    always_comb begin
        valid_d  = valid_q;
        count_d  = count_q;
        entry_d  = entry_q;
        ageAlloc = '0;
        ageFree  = '0;
        if (flush) begin
            valid_d = '0;
            count_d = '0;
            ageFree = '1;
        end else begin
            for (int e = 0; e < RS_ENTRIES; e++) begin
                if (wbHit(entry_q[e].src1, wb_valid, wb_preg)) entry_d[e].src1_rdy = 1'b1;
                if (wbHit(entry_q[e].src2, wb_valid, wb_preg)) entry_d[e].src2_rdy = 1'b1;
            end
            valid_d = valid_q & ~issueFree;
            ageFree = issueFree;
            if (dispFire) begin
                for (int e = 0; e < RS_ENTRIES; e++) begin
                    if (allocOh[e]) begin
                        entry_d[e] = disp_uop;
                        entry_d[e].src1_rdy = disp_uop.src1_rdy || (disp_uop.src1 == '0)
                                              || wbHit(disp_uop.src1, wb_valid, wb_preg);
                        entry_d[e].src2_rdy = disp_uop.src2_rdy || (disp_uop.src2 == '0)
                                              || wbHit(disp_uop.src2, wb_valid, wb_preg);
                    end
                end
                valid_d  = valid_d | allocOh;
                ageAlloc = allocOh;
            end
            count_d = count_q + CNT_W'(dispFire) - issCount;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        entry_q <= entry_d;
    end

    assign rs_count = count_q;

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Directed bench for rs_issue_scheduler: wakeup, bypass, age-ordered issue, full, flush and reset.
// Inputs change just after the falling edge; outputs are checked 1ns later, well clear of the rising edge.
module tb_rs_issue_scheduler;
    import rs_issue_scheduler_pkg::*;

    logic                      clk;
    logic                      rst;
    logic                      flush;
    logic                      disp_valid;
    logic                      disp_ready;
    Disp_uOP                   disp_uop;
    logic [NUM_WB-1:0]         wb_valid;
    logic [NUM_WB*PREG_W-1:0]  wb_preg;
    logic [NUM_FUS-1:0]        iss_valid;
    logic [NUM_FUS-1:0]        iss_ready;
    Sel_uOP [NUM_FUS-1:0]      iss_uop;
    logic [CNT_W-1:0]          rs_count;

    int checks;
    int errors;
    int fires;

    rs_issue_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .disp_valid (disp_valid),
        .disp_ready (disp_ready),
        .disp_uop   (disp_uop),
        .wb_valid   (wb_valid),
        .wb_preg    (wb_preg),
        .iss_valid  (iss_valid),
        .iss_ready  (iss_ready),
        .iss_uop    (iss_uop),
        .rs_count   (rs_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts accepted handshakes so a uOP issued twice shows up in the final total.
    always @(posedge clk) begin
        if (!rst && !flush) begin
            for (int f = 0; f < NUM_FUS; f++) begin
                if (iss_valid[f] && iss_ready[f]) fires++;
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic Disp_uOP mkUop(input int fu, input int s1, input int s2,
                                      input int r1, input int r2, input int dst, input int pl);
        Disp_uOP u;
        u.fu_id    = FU_W'(fu);
        u.src1     = PREG_W'(s1);
        u.src2     = PREG_W'(s2);
        u.src1_rdy = (r1 != 0);
        u.src2_rdy = (r2 != 0);
        u.dest     = PREG_W'(dst);
        u.payload  = PAYLOAD_W'(pl);
        return u;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input Disp_uOP u);
        disp_valid = 1'b1;
        disp_uop   = u;
    endtask

    task automatic setWb(input int k, input int tag);
        wb_valid[k] = 1'b1;
        wb_preg[k*PREG_W +: PREG_W] = PREG_W'(tag);
    endtask

    task automatic clearWb();
        wb_valid = '0;
        wb_preg  = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        fires      = 0;
        rst        = 1'b1;
        flush      = 1'b0;
        disp_valid = 1'b0;
        disp_uop   = '0;
        iss_ready  = '0;
        clearWb();

        // Reset held three cycles
        #1 checkOutput("rstDispReady", 32'(disp_ready), 0);
        repeat (3) cyc();
        rst = 1'b0;
        #1;
        checkOutput("rstCount", 32'(rs_count), 0);
        checkOutput("rstIssValid", 32'(iss_valid), 0);
        checkOutput("readyAfterRst", 32'(disp_ready), 1);

        // Wakeup latency: wb one cycle after dispatch, eligible the cycle after that
        applyStimulus(mkUop(2, 5, 0, 0, 0, 12, 'hA1));
        cyc();
        disp_valid = 1'b0;
        setWb(0, 5);
        #1;
        checkOutput("wkCount1", 32'(rs_count), 1);
        checkOutput("wkNotSameCycle", 32'(iss_valid), 0);
        cyc();
        clearWb();
        #1;
        checkOutput("wkIssValid", 32'(iss_valid), 32'b0100);
        checkOutput("wkPayload", 32'(iss_uop[2].payload), 'hA1);
        iss_ready = 4'b0100;
        cyc();
        iss_ready = '0;
        #1;
        checkOutput("wkCount0", 32'(rs_count), 0);
        checkOutput("wkIssValid0", 32'(iss_valid), 0);

        // In-order issue on FU1; D reuses freed slot 0 but must still issue after C
        applyStimulus(mkUop(1, 0, 0, 1, 1, 1, 'hB0));
        cyc();
        applyStimulus(mkUop(1, 0, 0, 1, 1, 2, 'hB1));
        #1 checkOutput("ordHoldA", 32'(iss_uop[1].payload), 'hB0);
        cyc();
        applyStimulus(mkUop(1, 0, 0, 1, 1, 3, 'hB2));
        cyc();
        disp_valid = 1'b0;
        iss_ready  = 4'b0010;
        #1;
        checkOutput("ordCount3", 32'(rs_count), 3);
        checkOutput("ordA", 32'(iss_uop[1].payload), 'hB0);
        cyc();
        applyStimulus(mkUop(1, 0, 0, 1, 1, 4, 'hB3));
        #1;
        checkOutput("ordB", 32'(iss_uop[1].payload), 'hB1);
        checkOutput("ordCount2", 32'(rs_count), 2);
        cyc();
        disp_valid = 1'b0;
        #1;
        checkOutput("ordC", 32'(iss_uop[1].payload), 'hB2);
        checkOutput("ordCountD", 32'(rs_count), 2);
        cyc();
        #1 checkOutput("ordD", 32'(iss_uop[1].payload), 'hB3);
        cyc();
        iss_ready = '0;
        #1;
        checkOutput("ordCount0", 32'(rs_count), 0);
        checkOutput("ordIssValid0", 32'(iss_valid), 0);

        // Fill all slots waiting on preg 7, then one broadcast releases them
        for (int i = 0; i < RS_ENTRIES; i++) begin
            applyStimulus(mkUop(i % NUM_FUS, 7, 0, 0, 0, i + 1, 'hC0 + i));
            cyc();
        end
        applyStimulus(mkUop(0, 0, 0, 1, 1, 9, 'hCF));
        #1;
        checkOutput("fullDispReady", 32'(disp_ready), 0);
        checkOutput("fullCount", 32'(rs_count), 8);
        checkOutput("fullIssValid", 32'(iss_valid), 0);
        iss_ready = 4'b1111;
        setWb(1, 7);
        cyc();
        clearWb();
        #1;
        checkOutput("fullIssAll", 32'(iss_valid), 32'b1111);
        checkOutput("fullIssueNoDisp", 32'(disp_ready), 0);
        for (int f = 0; f < NUM_FUS; f++)
            checkOutput($sformatf("fullFirst%0d", f), 32'(iss_uop[f].payload), 'hC0 + f);
        cyc();
        disp_valid = 1'b0;
        #1;
        checkOutput("fullCount4", 32'(rs_count), 4);
        checkOutput("fullIssAll2", 32'(iss_valid), 32'b1111);
        for (int f = 0; f < NUM_FUS; f++)
            checkOutput($sformatf("fullSecond%0d", f), 32'(iss_uop[f].payload), 'hC4 + f);
        cyc();
        iss_ready = '0;
        #1 checkOutput("fullDrained", 32'(rs_count), 0);

        // Dispatch bypass, post-dispatch wakeup, and preg 0 always ready
        applyStimulus(mkUop(3, 9, 0, 0, 0, 20, 'hD0));
        setWb(1, 9);
        cyc();
        clearWb();
        applyStimulus(mkUop(0, 9, 0, 0, 0, 21, 'hD1));
        #1;
        checkOutput("bypassValid", 32'(iss_valid), 32'b1000);
        checkOutput("bypassPayload", 32'(iss_uop[3].payload), 'hD0);
        cyc();
        applyStimulus(mkUop(2, 0, 0, 0, 0, 22, 'hD2));
        setWb(0, 9);
        #1 checkOutput("lateWbNotYet", 32'(iss_valid), 32'b1000);
        cyc();
        disp_valid = 1'b0;
        clearWb();
        #1;
        checkOutput("lateWbValid", 32'(iss_valid), 32'b1101);
        checkOutput("lateWbPayload", 32'(iss_uop[0].payload), 'hD1);
        checkOutput("preg0Payload", 32'(iss_uop[2].payload), 'hD2);
        checkOutput("bypassCount", 32'(rs_count), 3);
        iss_ready = 4'b1111;
        cyc();
        iss_ready = '0;
        #1 checkOutput("bypassDrained", 32'(rs_count), 0);

        // Flush with five ready entries while every FU accepts
        for (int i = 0; i < 5; i++) begin
            applyStimulus(mkUop(i % NUM_FUS, 0, 0, 1, 1, i, 'hE0 + i));
            cyc();
        end
        disp_valid = 1'b0;
        #1;
        checkOutput("flushCount5", 32'(rs_count), 5);
        checkOutput("flushIssValid", 32'(iss_valid), 32'b1111);
        iss_ready = 4'b1111;
        flush     = 1'b1;
        #1 checkOutput("flushDispReady", 32'(disp_ready), 0);
        cyc();
        flush = 1'b0;
        #1;
        checkOutput("flushCount0", 32'(rs_count), 0);
        checkOutput("flushIssValid0", 32'(iss_valid), 0);
        cyc();
        iss_ready = '0;
        #1 checkOutput("flushStillEmpty", 32'(rs_count), 0);

        // Reset mid-stream discards the pending handshake on F1
        applyStimulus(mkUop(1, 0, 0, 1, 1, 0, 'hF0));
        cyc();
        applyStimulus(mkUop(1, 0, 0, 1, 1, 1, 'hF1));
        iss_ready = 4'b0010;
        #1 checkOutput("midF0", 32'(iss_uop[1].payload), 'hF0);
        cyc();
        applyStimulus(mkUop(1, 0, 0, 1, 1, 2, 'hF2));
        #1;
        checkOutput("midCount1", 32'(rs_count), 1);
        checkOutput("midF1", 32'(iss_uop[1].payload), 'hF1);
        rst = 1'b1;
        #1 checkOutput("midRstDispReady", 32'(disp_ready), 0);
        cyc();
        rst        = 1'b0;
        disp_valid = 1'b0;
        #1;
        checkOutput("midRstCount", 32'(rs_count), 0);
        checkOutput("midRstIssValid", 32'(iss_valid), 0);
        cyc();
        iss_ready = '0;
        #1;
        checkOutput("midRstStillEmpty", 32'(rs_count), 0);
        checkOutput("totalHandshakes", 32'(fires), 17);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
